// File: rtl/mmio_uart_pkg.sv
// Shared types and constants for the MMIO UART transmitter.
package mmio_uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam logic [31:0] TX_ADDR_DEF   = 32'h0000_0200;
    localparam logic [31:0] STAT_ADDR_DEF = 32'h0000_0204;

    localparam int STAT_BUSY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-bus UART transmitter: address decode, overflow flag,
// 8N1 shift FSM and combinational status readback.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] TX_ADDR      = TX_ADDR_DEF,
    parameter logic [31:0] STAT_ADDR    = STAT_ADDR_DEF,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          DEPTH        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadDataIO,
    output logic        tx,
    output logic        busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    uart_state_t   state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          overflow;

    logic          push_req;
    logic          clr_req;
    logic          pop;
    logic          baud_last;
    logic          full;
    logic          empty;
    logic [7:0]    head;
    logic          unused_wdata;

    assign unused_wdata = ^WriteData[31:8];

    assign push_req  = MemWrite && (DataAdr == TX_ADDR);
    assign clr_req   = MemWrite && (DataAdr == STAT_ADDR) && WriteData[0];
    assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));
    assign pop       = !empty &&
                       ((state == IDLE) || (state == STOP && baud_last));
    assign busy      = (state != IDLE) || !empty;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push_req),
        .pop  (pop),
        .din  (WriteData[7:0]),
        .dout (head),
        .full (full),
        .empty(empty)
    );

    always_comb begin
        ReadDataIO = '0;
        if (DataAdr == STAT_ADDR) begin
            ReadDataIO[STAT_BUSY] = busy;
            ReadDataIO[STAT_FULL] = full;
            ReadDataIO[STAT_OVF]  = overflow;
        end
    end

    // A dropped push beats a clear arriving on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push_req && full && !pop) begin
            overflow <= 1'b1;
        end else if (clr_req) begin
            overflow <= 1'b0;
        end
    end

    // tx is registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            unique case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift[0];
                default: tx <= 1'b1;
            endcase

            unique case (state)
                IDLE: begin
                    baud    <= '0;
                    bit_idx <= '0;
                    if (!empty) begin
                        shift <= head;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud  <= '0;
                        shift <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (!empty) begin
                            shift <= head;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized scoreboard bench for mmio_uart_tx with a frame-level
// reference model and a serial decoder on the tx line.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] TXA   = 32'h0000_0200;
    localparam logic [31:0] STA   = 32'h0000_0204;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadDataIO;
    logic        tx;
    logic        busy;

    mmio_uart_tx #(
        .TX_ADDR     (TXA),
        .STAT_ADDR   (STA),
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadDataIO(ReadDataIO),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         errors  = 0;
    logic [7:0] mq[$];
    logic [7:0] sb[$];
    int         t = 0;
    int         next_free = 0;
    bit         fr_valid = 0;
    int         fr_p = 0;
    logic [7:0] fr_byte = 8'h00;
    bit         m_ovf = 0;
    bit         done = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    // Transmitter may start a frame once the previous one has reached its
    // final stop cycle; a frame popped at edge P owns tx for edges P+1..P+10*CPB.
    function automatic bit m_busy();
        return (t < next_free) || (mq.size() != 0);
    endfunction

    function automatic logic exp_tx();
        int k;
        if (!fr_valid || t < fr_p + 1 || t > fr_p + 10 * CPB) return 1'b1;
        k = (t - fr_p - 1) / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return fr_byte[k-1];
    endfunction

    task automatic model_edge();
        bit pop;
        bit was_full;
        t++;
        if (reset) begin
            mq.delete();
            sb.delete();
            fr_valid  = 0;
            next_free = 0;
            m_ovf     = 0;
            return;
        end
        pop      = (t >= next_free) && (mq.size() != 0);
        was_full = (mq.size() == DEPTH);
        if (pop) begin
            fr_byte   = mq.pop_front();
            fr_p      = t;
            fr_valid  = 1;
            next_free = t + 10 * CPB;
        end
        if (MemWrite && DataAdr == STA && WriteData[0]) m_ovf = 0;
        if (MemWrite && DataAdr == TXA) begin
            if (!was_full || pop) begin
                mq.push_back(WriteData[7:0]);
                sb.push_back(WriteData[7:0]);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic step();
        logic [31:0] st;
        @(posedge clk);
        model_edge();
        #1;
        st = (DataAdr == STA) ?
             {29'b0, m_ovf, (mq.size() == DEPTH), m_busy()} : 32'b0;
        check("tx", {31'b0, tx}, {31'b0, exp_tx()});
        check("busy", {31'b0, busy}, {31'b0, m_busy()});
        check("status", ReadDataIO, st);
    endtask

    task automatic idle();
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
    endtask

    task automatic store(logic [31:0] a, logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        step();
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 4000 && (m_busy() || busy); i++) step();
        check("drain", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 2 * CPB; i++) step();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        DataAdr = STA;
        fork
            begin : driver
                int e;
                step();
                step();
                check("reset_tx", {31'b0, tx}, 32'd1);
                check("reset_busy", {31'b0, busy}, 32'd0);
                check("reset_stat", ReadDataIO, 32'd0);
                reset = 1'b0;
                idle();
                step();

                store(TXA, 32'hABCD_EF55);
                e = t;
                idle();
                for (int i = 0; i < 42; i++) begin
                    step();
                    if (t == e + 2) check("first_low", {31'b0, tx}, 32'd0);
                    if (t == e + 40) check("busy_e40", {31'b0, busy}, 32'd1);
                end
                check("busy_e42", {31'b0, busy}, 32'd0);

                store(32'd100, 32'd7);
                store(32'd96, 32'h12);
                idle();
                for (int i = 0; i < 6; i++) step();
                check("ignored_busy", {31'b0, busy}, 32'd0);

                DataAdr = STA;
                step();
                check("poll_idle", ReadDataIO, 32'd0);
                DataAdr = 32'h208;
                step();
                check("poll_other", ReadDataIO, 32'd0);

                for (int i = 1; i <= 10; i++) store(TXA, i);
                idle();
                DataAdr = STA;
                step();
                check("ovf_full", ReadDataIO, 32'h7);
                store(STA, 32'h1);
                check("ovf_clear", ReadDataIO, 32'h3);
                drain();

                store(TXA, 32'hA5);
                for (int i = 0; i < 3; i++) store(TXA, $urandom_range(0, 255));
                idle();
                for (int i = 0; i < 10; i++) step();
                reset   = 1'b1;
                DataAdr = STA;
                step();
                reset = 1'b0;
                check("rst_tx", {31'b0, tx}, 32'd1);
                check("rst_busy", {31'b0, busy}, 32'd0);
                check("rst_full", {31'b0, ReadDataIO[1]}, 32'd0);
                idle();
                for (int i = 0; i < 60; i++) step();

                for (int b = 0; b < 3; b++) begin
                    for (int i = 0; i < 6; i++)
                        store(TXA, $urandom());
                    drain();
                end

                for (int i = 0; i < 600; i++) begin
                    int r;
                    r = $urandom_range(0, 9);
                    if (r <= 2) store(TXA, $urandom());
                    else if (r == 3) store(STA, $urandom());
                    else if (r == 4) store($urandom_range(0, 1023) & ~32'h3, $urandom());
                    else if (r == 5) begin
                        idle();
                        DataAdr = STA;
                        step();
                    end else begin
                        idle();
                        step();
                    end
                end
                drain();
                check("sb_empty", sb.size(), 32'd0);
                done = 1;
            end
            begin : monitor
                bit         rx_on;
                int         cnt;
                int         k;
                logic [7:0] rx;
                logic [7:0] want;
                rx_on = 0;
                cnt   = 0;
                rx    = 8'h00;
                while (!done) begin
                    @(negedge clk);
                    if (reset) rx_on = 0;
                    else if (!rx_on) begin
                        if (tx === 1'b0) begin
                            rx_on = 1;
                            cnt   = 0;
                        end
                    end else cnt++;
                    if (rx_on && !reset && (cnt % CPB) == CPB / 2) begin
                        k = cnt / CPB;
                        if (k == 0) check("rx_start", {31'b0, tx}, 32'd0);
                        else if (k <= 8) rx[k-1] = tx;
                        else begin
                            check("rx_stop", {31'b0, tx}, 32'd1);
                            rx_on = 0;
                            if (sb.size() == 0) begin
                                vectors++;
                                errors++;
                                $display("FAIL rx_unexpected t=%0d: got %h expected none", t, rx);
                            end else begin
                                want = sb.pop_front();
                                check("rx_byte", {24'b0, rx}, {24'b0, want});
                            end
                        end
                    end
                end
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
